// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-type and line-level
// constants, and the parity helper used by both the transmit and receive paths.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_START  = 3'b001,
      ST_DATA   = 3'b010,
      ST_PARITY = 3'b011,
      ST_STOP   = 3'b100
   } tx_state_e;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;

   // data_xor is the XOR-reduction of the data word.
   function automatic logic parity_bit(input logic data_xor, input logic par_typ);
      logic p;
      case (par_typ)
         PAR_EVEN: p = data_xor;
         PAR_ODD:  p = ~data_xor;
         default:  p = data_xor;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the latched word and the data-bit index; supplies the bit the line
// will carry on the next cycle so the top can keep TX_OUT registered.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  ser_en,
   output logic                  ser_bit,
   output logic                  ser_done,
   output logic [DATA_WIDTH-1:0] ser_word
);

   localparam int PAD_W = 1 << CNT_WIDTH;

   logic [DATA_WIDTH-1:0] data_q;
   logic [CNT_WIDTH-1:0]  idx_q;
   logic [CNT_WIDTH-1:0]  nxt_idx;
   logic [PAD_W-1:0]      data_pad;

   assign ser_done = ser_en && (idx_q == CNT_WIDTH'(DATA_WIDTH - 1));
   assign ser_word = data_q;

   // Outside DATA the next bit is bit 0 (the START->DATA transition);
   // inside DATA it is the bit after the one currently on the line.
   assign nxt_idx  = ser_en ? idx_q + CNT_WIDTH'(1) : '0;
   assign data_pad = PAD_W'(data_q);
   assign ser_bit  = data_pad[nxt_idx];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         data_q <= '0;
         idx_q  <= '0;
      end else begin
         if (load) begin
            data_q <= load_data;
         end
         if (ser_en && !ser_done) begin
            idx_q <= idx_q + CNT_WIDTH'(1);
         end else begin
            idx_q <= '0;
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit, at one CLK per bit. TX_OUT and Busy come straight from flops.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  Busy
);

   tx_state_e             state_q, state_d;
   logic                  tx_d, busy_d;
   logic                  load;
   logic                  par_en_q, par_typ_q;
   logic                  ser_en, ser_bit, ser_done;
   logic [DATA_WIDTH-1:0] ser_word;

   assign ser_en = (state_q == ST_DATA);

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_ser (
      .CLK       (CLK),
      .RST       (RST),
      .load      (load),
      .load_data (P_DATA),
      .ser_en    (ser_en),
      .ser_bit   (ser_bit),
      .ser_done  (ser_done),
      .ser_word  (ser_word)
   );

   // Outputs are decoded from the next state so they appear registered
   // in the same cycle the FSM enters that state.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      tx_d    = LINE_IDLE;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (Data_Valid) begin
               load    = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START:  state_d = ST_DATA;
         ST_DATA: begin
            if (ser_done) begin
               state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: state_d = ST_STOP;
         ST_STOP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      case (state_d)
         ST_START:  tx_d = START_BIT;
         ST_DATA:   tx_d = ser_bit;
         ST_PARITY: tx_d = parity_bit(^ser_word, par_typ_q);
         default:   tx_d = LINE_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         TX_OUT    <= LINE_IDLE;
         Busy      <= 1'b0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         state_q <= state_d;
         TX_OUT  <= tx_d;
         Busy    <= busy_d;
         if (load) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level reference model queues the expected line
// level for every busy cycle; a negedge monitor compares TX_OUT and Busy each cycle.
module tb_uart_tx;

   localparam int DW = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] P_DATA = '0;
   logic          Data_Valid = 1'b0;
   logic          PAR_EN = 1'b0;
   logic          PAR_TYP = 1'b0;
   logic          TX_OUT;
   logic          Busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int free_at  = 0;
   logic exp_q[$];

   uart_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   // clock
   always #5 CLK = ~CLK;

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
      end
   endtask

   // Reference model: a strobe seen at edge e is taken only if the previous
   // frame has ended and one idle cycle has followed; the frame is then queued.
   always @(posedge CLK) begin
      if (RST && Data_Valid && cyc >= free_at) begin
         int ones;
         int len;
         ones = $countones(P_DATA);
         exp_q.push_back(1'b0);
         for (int i = 0; i < DW; i++) exp_q.push_back(P_DATA[i]);
         len = DW + 2;
         if (PAR_EN) begin
            // even: total ones even; odd: total ones odd
            exp_q.push_back(PAR_TYP ? ((ones % 2) == 0) : ((ones % 2) == 1));
            len = DW + 3;
         end
         exp_q.push_back(1'b1);
         free_at = cyc + len + 1;
      end
      cyc++;
   end

   // monitor / scoreboard
   always @(negedge CLK) begin
      logic exp_busy;
      logic exp_tx;
      exp_busy = (exp_q.size() > 0);
      exp_tx   = exp_busy ? exp_q[0] : 1'b1;
      check_bit("busy", Busy, exp_busy);
      check_bit("tx_out", TX_OUT, exp_tx);
      if (exp_busy) void'(exp_q.pop_front());
   end

   // driver tasks (called at a negedge)
   task automatic send(input logic [DW-1:0] d, input logic pen, input logic ptyp);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0 && Busy === 1'b0) begin
            idle = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      checks++;
      if (!idle) begin
         failures++;
         $display("FAIL wait_idle timeout actual_busy=%b required_busy=0 pending=%0d", Busy, exp_q.size());
      end
      @(negedge CLK);
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      check_bit("reset_tx", TX_OUT, 1'b1);
      check_bit("reset_busy", Busy, 1'b0);
      RST = 1'b1;
      repeat (20) @(negedge CLK);

      send(8'hA5, 1'b0, 1'b0);
      wait_idle();
      send(8'h0F, 1'b1, 1'b0);
      wait_idle();
      send(8'h0F, 1'b1, 1'b1);
      wait_idle();

      // strobes mid-DATA and in the STOP cycle must be dropped
      send(8'h3C, 1'b0, 1'b0);
      repeat (3) @(negedge CLK);
      P_DATA = 8'hFF; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      repeat (5) @(negedge CLK);
      P_DATA = 8'hFF; Data_Valid = 1'b1;
      @(negedge CLK);
      Data_Valid = 1'b0;
      wait_idle();

      // held strobe: frames separated by a single idle cycle
      P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
      repeat (34) @(negedge CLK);
      Data_Valid = 1'b0;
      wait_idle();

      // reset during data bit 4
      send(8'h81, 1'b0, 1'b0);
      repeat (5) @(negedge CLK);
      #2;
      RST = 1'b0;
      exp_q.delete();
      free_at = 0;
      #1;
      check_bit("midreset_tx", TX_OUT, 1'b1);
      check_bit("midreset_busy", Busy, 1'b0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      send(8'h81, 1'b0, 1'b0);
      wait_idle();

      // randomized traffic, gaps short enough that some strobes are dropped
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 12)) @(negedge CLK);
         send(DW'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
